// File: rtl/i2c_master_ctrl_if.sv
// Host command/response bundle for the single-byte I2C master sequencer.
interface i2c_master_ctrl_if;
    logic       cmd_valid_i;
    logic       cmd_ready_o;
    logic [6:0] cmd_addr_i;
    logic       cmd_rw_i;
    logic [7:0] cmd_wdata_i;
    logic [7:0] rdata_o;
    logic       done_o;
    logic       nack_o;
    logic       busy_o;

    modport master (
        output cmd_valid_i, cmd_addr_i, cmd_rw_i, cmd_wdata_i,
        input  cmd_ready_o, rdata_o, done_o, nack_o, busy_o
    );

    modport slave (
        input  cmd_valid_i, cmd_addr_i, cmd_rw_i, cmd_wdata_i,
        output cmd_ready_o, rdata_o, done_o, nack_o, busy_o
    );
endinterface

// File: rtl/i2c_master_ctrl.sv
// Single-byte I2C master: START, address+R/W, one data byte, ACK handling, STOP.
// Edge-driven off the SCL returned by an external divided clock generator.
module i2c_master_ctrl #(
    parameter int SCL_HALF   = 4,
    parameter int START_HOLD = 4,
    parameter int STOP_HOLD  = 4
) (
    input  logic               i2c_core_clk_i,
    input  logic               i2c_core_rst_i,
    i2c_master_ctrl_if.slave   host,
    output logic               clk_en_o,
    input  logic               i2c_scl_i,
    input  logic               i2c_sda_i,
    output logic               i2c_sda_en_o
);
    typedef enum logic [3:0] {
        S_IDLE, S_START, S_ADDR, S_ADDR_ACK, S_WR, S_WR_ACK,
        S_RD, S_MACK, S_STOP, S_STOP_WAIT, S_STOP_HOLD
    } state_t;

    state_t      r_state;
    logic        r_scl_d;
    logic        r_clk_en;
    logic        r_sda_en;
    logic        r_done;
    logic        r_nack;
    logic        r_rw;
    logic [7:0]  r_sh;
    logic [7:0]  r_wdata;
    logic [7:0]  r_rdata;
    logic [3:0]  r_bit;
    logic [15:0] r_cnt;
    logic        w_fall;
    logic        w_rise;

    assign w_fall = r_scl_d & ~i2c_scl_i;
    assign w_rise = ~r_scl_d & i2c_scl_i;

    assign clk_en_o         = r_clk_en;
    assign i2c_sda_en_o     = r_sda_en;
    assign host.cmd_ready_o = (r_state == S_IDLE);
    assign host.busy_o      = (r_state != S_IDLE);
    assign host.done_o      = r_done;
    assign host.nack_o      = r_nack;
    assign host.rdata_o     = r_rdata;

    always_ff @(posedge i2c_core_clk_i) begin
        if (i2c_core_rst_i) begin
            r_state  <= S_IDLE;
            r_scl_d  <= 1'b1;
            r_clk_en <= 1'b0;
            r_sda_en <= 1'b0;
            r_done   <= 1'b0;
            r_nack   <= 1'b0;
            r_rw     <= 1'b0;
            r_sh     <= '0;
            r_wdata  <= '0;
            r_rdata  <= '0;
            r_bit    <= '0;
            r_cnt    <= '0;
        end else begin
            r_scl_d <= i2c_scl_i;
            r_done  <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    r_sda_en <= 1'b0;
                    r_clk_en <= 1'b0;
                    if (host.cmd_valid_i) begin
                        r_sh     <= {host.cmd_addr_i, host.cmd_rw_i};
                        r_rw     <= host.cmd_rw_i;
                        r_wdata  <= host.cmd_wdata_i;
                        r_nack   <= 1'b0;
                        r_sda_en <= 1'b1;
                        r_cnt    <= '0;
                        r_state  <= S_START;
                    end
                end
                S_START: begin
                    if (r_cnt == 16'(START_HOLD - 1)) begin
                        r_clk_en <= 1'b1;
                        r_bit    <= '0;
                        r_state  <= S_ADDR;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                S_ADDR, S_WR: begin
                    if (w_fall) begin
                        if (r_bit == 4'd8) begin
                            r_sda_en <= 1'b0;
                            r_state  <= (r_state == S_ADDR) ? S_ADDR_ACK
                                                             : S_WR_ACK;
                        end else begin
                            r_sda_en <= ~r_sh[7];
                            r_sh     <= {r_sh[6:0], 1'b0};
                            r_bit    <= r_bit + 4'd1;
                        end
                    end
                end
                S_ADDR_ACK: begin
                    if (w_rise) begin
                        r_nack <= i2c_sda_i;
                    end else if (w_fall) begin
                        r_bit <= '0;
                        if (r_nack) begin
                            r_sda_en <= 1'b1;
                            r_cnt    <= '0;
                            r_state  <= S_STOP;
                        end else if (!r_rw) begin
                            // first data bit goes out on this same fall
                            r_sda_en <= ~r_wdata[7];
                            r_sh     <= {r_wdata[6:0], 1'b0};
                            r_bit    <= 4'd1;
                            r_state  <= S_WR;
                        end else begin
                            r_sda_en <= 1'b0;
                            r_state  <= S_RD;
                        end
                    end
                end
                S_WR_ACK: begin
                    if (w_rise) begin
                        r_nack <= i2c_sda_i;
                    end else if (w_fall) begin
                        r_sda_en <= 1'b1;
                        r_cnt    <= '0;
                        r_state  <= S_STOP;
                    end
                end
                S_RD: begin
                    if (w_rise) begin
                        r_rdata <= {r_rdata[6:0], i2c_sda_i};
                        r_bit   <= r_bit + 4'd1;
                    end else if (w_fall && r_bit == 4'd8) begin
                        r_sda_en <= 1'b0;
                        r_state  <= S_MACK;
                    end
                end
                S_MACK: begin
                    if (w_fall) begin
                        r_sda_en <= 1'b1;
                        r_cnt    <= '0;
                        r_state  <= S_STOP;
                    end
                end
                S_STOP: begin
                    if (r_cnt == 16'(SCL_HALF - 1)) begin
                        r_clk_en <= 1'b0;
                        r_state  <= S_STOP_WAIT;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                S_STOP_WAIT: begin
                    if (i2c_scl_i) begin
                        r_cnt   <= '0;
                        r_state <= S_STOP_HOLD;
                    end
                end
                S_STOP_HOLD: begin
                    if (r_cnt == 16'(STOP_HOLD - 1)) begin
                        r_sda_en <= 1'b0;
                        r_done   <= 1'b1;
                        r_state  <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_i2c_master_ctrl.sv
// Directed bench: SCL generator model, bus monitor and simple slave model.
module tb_i2c_master_ctrl;
    localparam int SCL_HALF = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic clk_en;
    logic sda_en;
    logic scl = 1'b1;
    logic sda;
    logic pull;
    int   gcnt = 0;
    int   phase = 0;

    int tests = 0;
    int fails = 0;

    logic       s_rw = 1'b0;
    logic       s_acka = 1'b0;
    logic       s_ackd = 1'b0;
    logic [7:0] s_rbyte = 8'h00;

    logic p_scl = 1'b1;
    logic p_sda = 1'b1;
    int   starts = 0;
    int   stops = 0;
    int   dones = 0;
    int   falls = 0;
    bit   bits[$];

    bit   got_done;
    logic got_nack;

    i2c_master_ctrl_if bus();

    i2c_master_ctrl #(
        .SCL_HALF(SCL_HALF), .START_HOLD(4), .STOP_HOLD(4)
    ) dut (
        .i2c_core_clk_i(clk),
        .i2c_core_rst_i(rst),
        .host(bus),
        .clk_en_o(clk_en),
        .i2c_scl_i(scl),
        .i2c_sda_i(sda),
        .i2c_sda_en_o(sda_en)
    );

    always #5 clk = ~clk;

    // divided SCL generator: returns high when disabled, start phase settable
    always @(posedge clk) begin
        if (rst || !clk_en) begin
            scl  <= 1'b1;
            gcnt <= phase;
        end else if (gcnt == SCL_HALF - 1) begin
            scl  <= ~scl;
            gcnt <= 0;
        end else begin
            gcnt <= gcnt + 1;
        end
    end

    always_comb begin
        pull = 1'b0;
        if (bus.busy_o) begin
            if (falls == 9)
                pull = s_acka;
            else if (!s_rw && falls == 18)
                pull = s_ackd;
            else if (s_rw && s_acka && falls >= 10 && falls <= 17)
                pull = ~s_rbyte[3'(17 - falls)];
        end
    end

    assign sda = ~(sda_en | pull);

    always @(negedge clk) begin
        p_scl <= scl;
        p_sda <= sda;
        if (scl && p_scl && p_sda && !sda) begin
            starts <= starts + 1;
            falls  <= 0;
            bits.delete();
        end else if (p_scl && !scl) begin
            falls <= falls + 1;
        end
        if (!p_scl && scl)
            bits.push_back(sda);
        if (scl && p_scl && !p_sda && sda)
            stops <= stops + 1;
        if (bus.done_o)
            dones <= dones + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] qbyte(input int base);
        logic [7:0] b;
        b = '0;
        for (int i = 0; i < 8; i++)
            if (base + i < bits.size())
                b[7 - i] = bits[base + i];
        return b;
    endfunction

    task automatic wait_done(input string tag);
        got_done = 1'b0;
        got_nack = 1'bx;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            #1;
            if (bus.done_o) begin
                got_done = 1'b1;
                got_nack = bus.nack_o;
                break;
            end
        end
        chk(tag, 32'(got_done), 32'd1);
    endtask

    task automatic xfer(input logic [6:0] a, input logic rw,
                        input logic [7:0] wd, input logic aa,
                        input logic ad, input logic [7:0] rb,
                        input int ph);
        s_rw    = rw;
        s_acka  = aa;
        s_ackd  = ad;
        s_rbyte = rb;
        phase   = ph;
        @(negedge clk);
        bus.cmd_addr_i  = a;
        bus.cmd_rw_i    = rw;
        bus.cmd_wdata_i = wd;
        bus.cmd_valid_i = 1'b1;
        @(posedge clk);
        #1;
        bus.cmd_valid_i = 1'b0;
    endtask

    int s0;
    int d0;
    int st0;
    bit hit;

    initial begin
        bus.cmd_valid_i = 1'b0;
        bus.cmd_addr_i  = '0;
        bus.cmd_rw_i    = 1'b0;
        bus.cmd_wdata_i = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst_ready", 32'(bus.cmd_ready_o), 32'd1);
        chk("rst_busy", 32'(bus.busy_o), 32'd0);
        chk("rst_clk_en", 32'(clk_en), 32'd0);
        chk("rst_sda_en", 32'(sda_en), 32'd0);
        chk("rst_done", 32'(bus.done_o), 32'd0);
        chk("rst_nack", 32'(bus.nack_o), 32'd0);
        chk("rst_rdata", 32'(bus.rdata_o), 32'd0);
        rst = 1'b0;

        // write 0x50 / 0xA5, both bytes ACKed
        s0 = starts; st0 = stops; d0 = dones;
        xfer(7'h50, 1'b0, 8'hA5, 1'b1, 1'b1, 8'h00, 0);
        wait_done("wr_done");
        chk("wr_nack", 32'(got_nack), 32'd0);
        chk("wr_addr", 32'(qbyte(0)), 32'hA0);
        chk("wr_aack", 32'(bits[8]), 32'd0);
        chk("wr_data", 32'(qbyte(9)), 32'hA5);
        chk("wr_dack", 32'(bits[17]), 32'd0);
        chk("wr_clocks", 32'(bits.size() - 1), 32'd18);
        chk("wr_start", 32'(starts - s0), 32'd1);
        chk("wr_stop", 32'(stops - st0), 32'd1);
        repeat (5) @(negedge clk);
        chk("wr_done_cnt", 32'(dones - d0), 32'd1);

        // read 0x3C, slave returns 0x96
        s0 = starts; st0 = stops;
        xfer(7'h3C, 1'b1, 8'h00, 1'b1, 1'b0, 8'h96, 2);
        wait_done("rd_done");
        chk("rd_nack", 32'(got_nack), 32'd0);
        chk("rd_addr", 32'(qbyte(0)), 32'h79);
        chk("rd_rdata", 32'(bus.rdata_o), 32'h96);
        chk("rd_mack", 32'(bits[17]), 32'd1);
        chk("rd_clocks", 32'(bits.size() - 1), 32'd18);
        chk("rd_stop", 32'(stops - st0), 32'd1);

        // address NACK
        st0 = stops;
        xfer(7'h21, 1'b0, 8'h77, 1'b0, 1'b0, 8'h00, 3);
        wait_done("an_done");
        chk("an_nack", 32'(got_nack), 32'd1);
        chk("an_addr", 32'(qbyte(0)), 32'h42);
        chk("an_ackbit", 32'(bits[8]), 32'd1);
        chk("an_clocks", 32'(bits.size() - 1), 32'd9);
        chk("an_stop", 32'(stops - st0), 32'd1);

        // data NACK
        xfer(7'h50, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1);
        wait_done("dn_done");
        chk("dn_nack", 32'(got_nack), 32'd1);
        chk("dn_data", 32'(qbyte(9)), 32'h00);
        chk("dn_clocks", 32'(bits.size() - 1), 32'd18);

        // reset at the 4th address bit
        xfer(7'h50, 1'b0, 8'hA5, 1'b1, 1'b1, 8'h00, 0);
        hit = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            #1;
            if (falls == 4) begin
                hit = 1'b1;
                break;
            end
        end
        chk("mr_reach", 32'(hit), 32'd1);
        d0  = dones;
        rst = 1'b1;
        @(negedge clk);
        #1;
        chk("mr_clk_en", 32'(clk_en), 32'd0);
        chk("mr_sda_en", 32'(sda_en), 32'd0);
        chk("mr_busy", 32'(bus.busy_o), 32'd0);
        chk("mr_ready", 32'(bus.cmd_ready_o), 32'd1);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        chk("mr_no_done", 32'(dones - d0), 32'd0);

        // held valid while busy, then back-to-back
        s0 = starts;
        s_rw = 1'b0; s_acka = 1'b1; s_ackd = 1'b1; phase = 1;
        @(negedge clk);
        bus.cmd_addr_i  = 7'h50;
        bus.cmd_rw_i    = 1'b0;
        bus.cmd_wdata_i = 8'h5A;
        bus.cmd_valid_i = 1'b1;
        @(posedge clk);
        #1;
        bus.cmd_addr_i  = 7'h12;
        bus.cmd_wdata_i = 8'hC3;
        repeat (30) @(negedge clk);
        #1;
        chk("bb_busy", 32'(bus.busy_o), 32'd1);
        chk("bb_ready", 32'(bus.cmd_ready_o), 32'd0);
        wait_done("bb_done1");
        chk("bb_nack1", 32'(got_nack), 32'd0);
        chk("bb_addr1", 32'(qbyte(0)), 32'hA0);
        chk("bb_data1", 32'(qbyte(9)), 32'h5A);
        chk("bb_start1", 32'(starts - s0), 32'd1);
        @(negedge clk);
        #1;
        chk("bb_accept2", 32'(bus.busy_o), 32'd1);
        bus.cmd_valid_i = 1'b0;
        wait_done("bb_done2");
        chk("bb_nack2", 32'(got_nack), 32'd0);
        chk("bb_addr2", 32'(qbyte(0)), 32'h24);
        chk("bb_data2", 32'(qbyte(9)), 32'hC3);
        chk("bb_start2", 32'(starts - s0), 32'd2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
